micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter: ADDR_W, 5, width of the microprogram address.
REQ-002 Parameter: STACK_DEPTH, 4, number of return-address stack entries (power of two, at least 2).
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: nReset  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  begin execution at address 0; sampled only in IDLE and HALT.
REQ-006 Port: instr  input  8  microword at addr from the combinational program ROM; [7:5]=op, [4:0]=operand.
REQ-007 Port: cy_flag  input  1  carry flag from the datapath.
REQ-008 Port: z_flag  input  1  accumulator-zero flag from the datapath.
REQ-009 Port: addr  output  ADDR_W  registered microprogram address to the ROM and control decoder.
REQ-010 Port: exec_en  output  1  datapath enable; Reg_CE, A_CE and CY_CE are ANDed with it externally.
REQ-011 Port: busy  output  1  high in RUN and WAIT.
REQ-012 Port: halted  output  1  high in HALT.
REQ-013 Port: err  output  1  sticky stack-fault flag; cleared only by reset or start.

Function
REQ-014 The FSM SHALL have four states, IDLE, RUN, WAIT and HALT, held in registers.
REQ-015 Op encodings SHALL be: 000 NEXT, 001 JMP, 010 JC, 011 JZ, 100 CALL, 101 RET, 110 DLY, 111 HALT.
REQ-016 IDLE/HALT with start=1 SHALL load addr=0, sp=0, err=0 and enter RUN on the next edge.
REQ-017 In RUN, instr SHALL be decoded every cycle, with the new addr valid one cycle later (single-cycle issue).
REQ-018 NEXT SHALL set addr=addr+1 modulo 2^ADDR_W, so 31 wraps to 0.
REQ-019 JMP SHALL set addr=operand; JC SHALL jump if cy_flag=1, else addr+1; JZ SHALL jump if z_flag=1, else addr+1.
REQ-020 CALL SHALL push addr+1 (modulo, wraps) to the stack, increment sp and set addr=operand.
REQ-021 RET SHALL pop: addr=stack[sp-1] and sp decrements.
REQ-022 CALL with sp=STACK_DEPTH SHALL NOT push, SHALL set err=1 and enter HALT with addr unchanged.
REQ-023 RET with sp=0 SHALL set err=1 and enter HALT with addr unchanged.
REQ-024 DLY with operand n>0 SHALL enter WAIT, hold addr for n further cycles, then continue at addr+1 in RUN.
REQ-025 DLY with n=0 SHALL behave exactly as NEXT.
REQ-026 The WAIT counter SHALL be 5 bits, load n on entry and decrement each cycle; at count 1 the next state SHALL be RUN with addr+1.
REQ-027 HALT op SHALL enter HALT with addr holding the HALT address.
REQ-028 exec_en SHALL be 1 only in RUN while op=NEXT or op=DLY (the cycle DLY is decoded); it SHALL be 0 in IDLE, WAIT and HALT and for flow-control ops.
REQ-029 busy and halted SHALL be decoded from registered state only, with no dependence on instr.
REQ-030 start asserted in RUN or WAIT SHALL be ignored.

Reset
REQ-031 nReset=1 at a clock edge SHALL force state=IDLE, addr=0, sp=0, wait counter=0, err=0.
REQ-032 During and after reset until start: exec_en=0, busy=0, halted=0.
REQ-033 Reset SHALL take priority over start and over any op, including mid-DLY and mid-CALL.
REQ-034 Stack contents need no reset value, but SHALL never be read when sp=0.

Verification
REQ-035 Reset then start, ROM = NEXT x3, HALT at address 3 -> addr sequence 0,1,2,3; exec_en=1 for 3 cycles; halted=1 with addr=3.
REQ-036 ROM[0]=JC 10 with cy=0, then rerun with cy=1 -> addr=1 in the first run and 10 in the second; JZ is checked the same way with z_flag.
REQ-037 ROM[0]=CALL 20, ROM[20]=RET, ROM[1]=HALT -> addr sequence 0,20,1; sp back to 0; err=0.
REQ-038 Five nested CALLs with STACK_DEPTH=4 -> the 5th CALL gives err=1 and halted=1; a RET at sp=0 also gives err=1.
REQ-039 ROM[0]=DLY 3 -> addr=0 for 4 cycles total, exec_en=1 only in the first, busy=1 throughout, then addr=1; DLY 0 gives addr=1 after one cycle.
REQ-040 Reset asserted in WAIT, and in a separate run a NEXT at addr 31 -> IDLE with addr=0 on the next edge; NEXT at 31 gives addr=0 while still in RUN.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks a combinational ROM and supports jumps, conditional
// branches, a small return stack and delay slots.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_RUN  | decoding instr at addr every cycle
// S_WAIT | DLY in progress, addr held while wait_cnt counts down
// S_HALT | stopped by a HALT op or a stack fault, waiting for start
module micro_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [7:0]        instr,
  input  logic              cy_flag,
  input  logic              z_flag,
  output logic [ADDR_W-1:0] addr,
  output logic              exec_en,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JC   = 3'b010;
  localparam logic [2:0] OP_JZ   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_DLY  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  state_t            state;
  logic [SP_W-1:0]   sp;
  logic [4:0]        wait_cnt;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [2:0]        op;
  logic [4:0]        operand;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] addr_inc;
  logic [SP_W-1:0]   sp_dec;
  logic              stack_full;
  logic              stack_empty;

  assign op          = instr[7:5];
  assign operand     = instr[4:0];
  assign target      = ADDR_W'(operand);
  assign addr_inc    = addr + ADDR_W'(1);
  assign sp_dec      = sp - SP_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  // exec_en follows the microword currently presented, so it is a decode of
  // the registered state and the ROM output rather than a registered copy.
  assign exec_en = (state == S_RUN) && ((op == OP_NEXT) || (op == OP_DLY));
  assign busy    = (state == S_RUN) || (state == S_WAIT);
  assign halted  = (state == S_HALT);

  // Stack storage carries no reset; sp guards every read.
  always_ff @(posedge clk) begin
    if (!nReset && state == S_RUN && op == OP_CALL && !stack_full)
      stack[sp[SP_W-2:0]] <= addr_inc;
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state    <= S_IDLE;
      addr     <= '0;
      sp       <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_RUN;
            addr     <= '0;
            sp       <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
          end
        end
        S_RUN: begin
          case (op)
            OP_NEXT: addr <= addr_inc;
            OP_JMP:  addr <= target;
            OP_JC:   addr <= cy_flag ? target : addr_inc;
            OP_JZ:   addr <= z_flag ? target : addr_inc;
            OP_CALL: begin
              if (stack_full) begin
                err   <= 1'b1;
                state <= S_HALT;
              end else begin
                sp   <= sp + SP_W'(1);
                addr <= target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                err   <= 1'b1;
                state <= S_HALT;
              end else begin
                sp   <= sp_dec;
                addr <= stack[sp_dec[SP_W-2:0]];
              end
            end
            OP_DLY: begin
              if (operand == 5'd0) begin
                addr <= addr_inc;
              end else begin
                wait_cnt <= operand;
                state    <= S_WAIT;
              end
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_HALT;
          endcase
        end
        S_WAIT: begin
          // Leaving at count 1 makes DLY n occupy n cycles after its issue cycle.
          if (wait_cnt <= 5'd1) begin
            wait_cnt <= '0;
            addr     <= addr_inc;
            state    <= S_RUN;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a small ROM array feeds instr and each
// task checks the address/flag trace against hand-derived values.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start;
  logic [7:0] instr;
  logic       cy_flag;
  logic       z_flag;
  logic [4:0] addr;
  logic       exec_en;
  logic       busy;
  logic       halted;
  logic       err;

  logic [7:0] rom [32];
  int total = 0;
  int bad   = 0;

  assign instr = rom[addr];

  micro_sequencer #(.ADDR_W(5), .STACK_DEPTH(4)) dut (
    .clk(clk), .nReset(nReset), .start(start), .instr(instr),
    .cy_flag(cy_flag), .z_flag(z_flag), .addr(addr), .exec_en(exec_en),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'hE0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b1; start = 1'b1;
    tick(); tick();
    total++; if (addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    total++; if (exec_en !== 1'b0) begin bad++; $display("FAIL reset_exec got=%0b exp=0", exec_en); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    start = 1'b0; nReset = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%0b exp=0", busy); end
  endtask

  task automatic test_linear();
    int ex_cnt;
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'hE0;
    pulse_start();
    ex_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      total++; if (addr !== 5'(i)) begin bad++; $display("FAIL linear_addr got=%0d exp=%0d", addr, i); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL linear_busy got=%0b exp=1", busy); end
      if (exec_en === 1'b1) ex_cnt++;
      tick();
    end
    total++; if (ex_cnt != 3) begin bad++; $display("FAIL linear_exec_cycles got=%0d exp=3", ex_cnt); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL linear_halted got=%0b exp=1", halted); end
    total++; if (addr !== 5'd3) begin bad++; $display("FAIL linear_halt_addr got=%0d exp=3", addr); end
    total++; if (busy !== 1'b0 || exec_en !== 1'b0) begin bad++; $display("FAIL linear_halt_flags busy=%0b exec=%0b exp=0,0", busy, exec_en); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = 8'h4A;
    cy_flag = 1'b0; z_flag = 1'b1;
    pulse_start();
    total++; if (exec_en !== 1'b0) begin bad++; $display("FAIL jc_exec got=%0b exp=0", exec_en); end
    tick();
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL jc_not_taken got=%0d exp=1", addr); end
    tick();
    cy_flag = 1'b1; z_flag = 1'b0;
    pulse_start();
    tick();
    total++; if (addr !== 5'd10) begin bad++; $display("FAIL jc_taken got=%0d exp=10", addr); end
    tick();
    rom[0] = 8'h6A;
    cy_flag = 1'b1; z_flag = 1'b0;
    pulse_start();
    tick();
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL jz_not_taken got=%0d exp=1", addr); end
    tick();
    cy_flag = 1'b0; z_flag = 1'b1;
    pulse_start();
    tick();
    total++; if (addr !== 5'd10) begin bad++; $display("FAIL jz_taken got=%0d exp=10", addr); end
    tick();
    z_flag = 1'b0;
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[0] = 8'h94; rom[20] = 8'hA0; rom[1] = 8'hE0;
    pulse_start();
    total++; if (exec_en !== 1'b0) begin bad++; $display("FAIL call_exec got=%0b exp=0", exec_en); end
    tick();
    total++; if (addr !== 5'd20) begin bad++; $display("FAIL call_target got=%0d exp=20", addr); end
    tick();
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL ret_addr got=%0d exp=1", addr); end
    total++; if (dut.sp !== 3'd0) begin bad++; $display("FAIL ret_sp got=%0d exp=0", dut.sp); end
    tick();
    total++; if (halted !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL call_ret_end halted=%0b err=%0b exp=1,0", halted, err); end
  endtask

  task automatic test_stack_fault();
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = 8'h80 | 8'(i + 1);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    total++; if (addr !== 5'd4 || busy !== 1'b1) begin bad++; $display("FAIL nest_depth4 addr=%0d busy=%0b exp=4,1", addr, busy); end
    tick();
    total++; if (err !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL overflow err=%0b halted=%0b exp=1,1", err, halted); end
    total++; if (addr !== 5'd4) begin bad++; $display("FAIL overflow_addr got=%0d exp=4", addr); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", err); end
    rom[0] = 8'hA0;
    pulse_start();
    total++; if (err !== 1'b0 || addr !== 5'd0) begin bad++; $display("FAIL start_clears_err err=%0b addr=%0d exp=0,0", err, addr); end
    tick();
    total++; if (err !== 1'b1 || halted !== 1'b1 || addr !== 5'd0) begin bad++; $display("FAIL underflow err=%0b halted=%0b addr=%0d exp=1,1,0", err, halted, addr); end
  endtask

  task automatic test_delay();
    clear_rom();
    rom[0] = 8'hC3;
    pulse_start();
    total++; if (addr !== 5'd0 || exec_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL dly_issue addr=%0d exec=%0b busy=%0b exp=0,1,1", addr, exec_en, busy); end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (addr !== 5'd0 || exec_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL dly_wait%0d addr=%0d exec=%0b busy=%0b exp=0,0,1", i, addr, exec_en, busy); end
    end
    start = 1'b0;
    tick();
    total++; if (addr !== 5'd1 || busy !== 1'b1) begin bad++; $display("FAIL dly_resume addr=%0d busy=%0b exp=1,1", addr, busy); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL dly_halt got=%0b exp=1", halted); end
    rom[0] = 8'hC0;
    pulse_start();
    total++; if (exec_en !== 1'b1) begin bad++; $display("FAIL dly0_exec got=%0b exp=1", exec_en); end
    tick();
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL dly0_addr got=%0d exp=1", addr); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL dly0_no_wait got=%0b exp=1", halted); end
  endtask

  task automatic test_reset_in_wait();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hC5;
    pulse_start();
    tick(); tick(); tick();
    total++; if (addr !== 5'd2 || busy !== 1'b1 || exec_en !== 1'b0) begin bad++; $display("FAIL pre_reset_wait addr=%0d busy=%0b exec=%0b exp=2,1,0", addr, busy, exec_en); end
    nReset = 1'b1; start = 1'b1;
    tick();
    total++; if (addr !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_in_wait addr=%0d busy=%0b halted=%0b exp=0,0,0", addr, busy, halted); end
    nReset = 1'b0; start = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_wait_reset got=%0b exp=0", busy); end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 8'h3F; rom[31] = 8'h00;
    pulse_start();
    total++; if (exec_en !== 1'b0) begin bad++; $display("FAIL jmp_exec got=%0b exp=0", exec_en); end
    tick();
    total++; if (addr !== 5'd31 || exec_en !== 1'b1) begin bad++; $display("FAIL jmp31 addr=%0d exec=%0b exp=31,1", addr, exec_en); end
    tick();
    total++; if (addr !== 5'd0 || busy !== 1'b1) begin bad++; $display("FAIL wrap addr=%0d busy=%0b exp=0,1", addr, busy); end
    tick();
    total++; if (addr !== 5'd31) begin bad++; $display("FAIL wrap_loop got=%0d exp=31", addr); end
    nReset = 1'b1;
    tick();
    total++; if (addr !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL wrap_reset addr=%0d busy=%0b exp=0,0", addr, busy); end
    nReset = 1'b0;
  endtask

  initial begin
    nReset = 1'b1; start = 1'b0; cy_flag = 1'b0; z_flag = 1'b0;
    clear_rom();
    test_reset();
    test_linear();
    test_branch();
    test_call_ret();
    test_stack_fault();
    test_delay();
    test_reset_in_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
